// File: rtl/controller_pkg.sv
// Shared opcode constants, FSM state encoding and ALUOp codes for the multicycle controller,
// plus the opcode decode used in every state.
package controller_pkg;

   localparam logic [6:0] OpRType = 7'b0110011;
   localparam logic [6:0] OpIType = 7'b0010011;
   localparam logic [6:0] OpLoad  = 7'b0000011;
   localparam logic [6:0] OpStore = 7'b0100011;
   localparam logic [6:0] OpBeq   = 7'b1100011;
   localparam logic [6:0] OpLui   = 7'b0110111;
   localparam logic [6:0] OpAuipc = 7'b0010111;
   localparam logic [6:0] OpJal   = 7'b1101111;
   localparam logic [6:0] OpJalr  = 7'b1100111;

   localparam logic [1:0] AluOpMem    = 2'b00;
   localparam logic [1:0] AluOpBranch = 2'b01;
   localparam logic [1:0] AluOpArith  = 2'b10;
   localparam logic [1:0] AluOpUJump  = 2'b11;

   typedef enum logic [2:0] {StFetch, StDecode, StExec, StMem, StWb} state_t;

   typedef struct packed {
      logic       legal;
      logic       alu_src;
      logic [1:0] alu_op;
      logic       is_load;
      logic       is_store;
      logic       is_branch;
      logic       is_jump;
   } decode_t;

   // Illegal opcodes decode to all zeros so ALUSrc/ALUOp stay quiet for them.
   function automatic decode_t decode_op(input logic [6:0] op, input logic jump_en);
      decode_t d;
      d = '0;
      case (op)
         OpRType: begin d.legal = 1'b1; d.alu_op = AluOpArith; end
         OpIType: begin d.legal = 1'b1; d.alu_src = 1'b1; d.alu_op = AluOpArith; end
         OpLoad:  begin d.legal = 1'b1; d.alu_src = 1'b1; d.alu_op = AluOpMem; d.is_load = 1'b1; end
         OpStore: begin d.legal = 1'b1; d.alu_src = 1'b1; d.alu_op = AluOpMem; d.is_store = 1'b1; end
         OpBeq:   begin d.legal = 1'b1; d.alu_op = AluOpBranch; d.is_branch = 1'b1; end
         OpLui:   begin d.legal = 1'b1; d.alu_src = 1'b1; d.alu_op = AluOpUJump; end
         OpAuipc: if (jump_en) begin d.legal = 1'b1; d.alu_src = 1'b1; d.alu_op = AluOpUJump; end
         OpJal:   if (jump_en) begin d.legal = 1'b1; d.alu_op = AluOpUJump; d.is_jump = 1'b1; end
         OpJalr: begin
            if (jump_en) begin
               d.legal   = 1'b1;
               d.alu_src = 1'b1;
               d.alu_op  = AluOpUJump;
               d.is_jump = 1'b1;
            end
         end
         default: d = '0;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts cycles spent waiting on data memory; expired is high in the TIMEOUT-th cycle of the
// wait so a completion arriving in that same cycle can still win.
module mem_wait_timer #(
   parameter int unsigned TIMEOUT = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic start,
   input  logic hold,
   input  logic done,
   output logic expired
);

   localparam int unsigned CntW = $clog2(TIMEOUT + 1);
   localparam logic [CntW-1:0] Last = CntW'(TIMEOUT - 1);

   logic [CntW-1:0] count_q, count_d;

   always_ff @(posedge clk) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   // Saturates at Last so expired stays asserted until the wait is resolved.
   always_comb begin
      count_d = count_q;
      if (start || done) begin
         count_d = '0;
      end else if (!hold && !expired) begin
         count_d = count_q + 1'b1;
      end
   end

   assign expired = (count_q == Last);

endmodule

// File: rtl/multicycle_controller.sv
// Five-state multicycle RISC-V control FSM (FETCH/DECODE/EXEC/MEM/WB) with hazard stall and
// optional data-memory timeout.
module multicycle_controller
   import controller_pkg::*;
#(
   parameter int unsigned MEM_TIMEOUT  = 16,
   parameter bit          SUPPORT_JUMP = 1'b1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [6:0] Opcode,
   input  logic       imem_ready,
   input  logic       dmem_ready,
   input  logic       stall,
   output logic       ALUSrc,
   output logic       MemtoReg,
   output logic       RegWrite,
   output logic       MemRead,
   output logic       MemWrite,
   output logic       Branch,
   output logic [1:0] ALUOp,
   output logic       Jump,
   output logic       IRWrite,
   output logic       PCWrite,
   output logic       illegal_instr,
   output logic       mem_error
);

   state_t     state_q, state_d;
   logic [6:0] op_q, op_d;
   logic       err_q, err_d;
   logic       mem_expired;
   decode_t    dec;

   assign dec = decode_op(op_q, SUPPORT_JUMP);

   generate
      if (MEM_TIMEOUT > 0) begin : g_timer
         logic timer_start, timer_done;
         assign timer_start = (state_q == StExec);
         assign timer_done  = (state_q == StMem) && dmem_ready;

         mem_wait_timer #(
            .TIMEOUT(MEM_TIMEOUT)
         ) u_mem_wait_timer (
            .clk    (clk),
            .reset  (reset),
            .start  (timer_start),
            .hold   (stall),
            .done   (timer_done),
            .expired(mem_expired)
         );
      end else begin : g_no_timer
         assign mem_expired = 1'b0;
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StFetch;
         op_q    <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         err_q   <= err_d;
      end
   end

   // err_q turns a timeout into a registered pulse seen in the following FETCH cycle.
   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      err_d   = 1'b0;
      if (!stall) begin
         unique case (state_q)
            StFetch: begin
               if (imem_ready) begin
                  op_d    = Opcode;
                  state_d = StDecode;
               end
            end
            StDecode: state_d = dec.legal ? StExec : StFetch;
            StExec: begin
               if (dec.is_load || dec.is_store) begin
                  state_d = StMem;
               end else if (dec.is_branch) begin
                  state_d = StFetch;
               end else begin
                  state_d = StWb;
               end
            end
            StMem: begin
               if (dmem_ready) begin
                  state_d = dec.is_load ? StWb : StFetch;
               end else if (mem_expired) begin
                  state_d = StFetch;
                  err_d   = 1'b1;
               end
            end
            StWb:    state_d = StFetch;
            default: state_d = StFetch;
         endcase
      end
   end

   always_comb begin
      ALUSrc        = dec.alu_src;
      ALUOp         = dec.alu_op;
      MemtoReg      = 1'b0;
      RegWrite      = 1'b0;
      MemRead       = 1'b0;
      MemWrite      = 1'b0;
      Branch        = 1'b0;
      Jump          = 1'b0;
      IRWrite       = 1'b0;
      PCWrite       = 1'b0;
      illegal_instr = 1'b0;
      mem_error     = err_q;
      unique case (state_q)
         StFetch:  IRWrite = imem_ready && !stall;
         StDecode: illegal_instr = !dec.legal && !stall;
         StExec: begin
            Branch  = dec.is_branch;
            PCWrite = dec.is_branch && !stall;
            Jump    = dec.is_jump;
         end
         StMem: begin
            MemRead  = dec.is_load;
            MemWrite = dec.is_store;
         end
         StWb: begin
            RegWrite = !stall;
            PCWrite  = !stall;
            MemtoReg = dec.is_load;
            Jump     = dec.is_jump;
         end
         default: begin
            ALUSrc = 1'b0;
            ALUOp  = 2'b00;
         end
      endcase
   end

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench: directed scenarios plus random instruction streams against a
// per-phase reference model of the controller's documented behaviour.
module tb_multicycle_controller;

   localparam int unsigned Timeout = 4;

   localparam logic [6:0] OpR     = 7'b0110011;
   localparam logic [6:0] OpI     = 7'b0010011;
   localparam logic [6:0] OpLw    = 7'b0000011;
   localparam logic [6:0] OpSw    = 7'b0100011;
   localparam logic [6:0] OpBeq   = 7'b1100011;
   localparam logic [6:0] OpLui   = 7'b0110111;
   localparam logic [6:0] OpAuipc = 7'b0010111;
   localparam logic [6:0] OpJal   = 7'b1101111;
   localparam logic [6:0] OpJalr  = 7'b1100111;

   localparam int PhF = 0, PhD = 1, PhE = 2, PhM = 3, PhW = 4;

   logic       clk = 1'b0;
   logic       reset;
   logic [6:0] Opcode;
   logic       imem_ready, dmem_ready, stall;
   logic       use_nj;
   logic       m_imem, m_stall, n_imem, n_stall;
   // {ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, ALUOp[1:0], Jump, IRWrite,
   //  PCWrite, illegal_instr, mem_error}
   wire  [12:0] m_out, n_out;

   int         n_asserts = 0;
   int         n_fail = 0;
   logic [6:0] last_op [2];
   bit         pending_err [2];
   logic [6:0] ops [10] = '{OpR, OpI, OpLw, OpSw, OpBeq, OpLui, OpAuipc, OpJal, OpJalr, 7'h7f};

   always #5 clk = ~clk;

   assign m_imem  = imem_ready & ~use_nj;
   assign m_stall = stall & ~use_nj;
   assign n_imem  = imem_ready & use_nj;
   assign n_stall = stall & use_nj;

   multicycle_controller #(.MEM_TIMEOUT(Timeout), .SUPPORT_JUMP(1'b1)) dut (
      .clk(clk), .reset(reset), .Opcode(Opcode), .imem_ready(m_imem), .dmem_ready(dmem_ready),
      .stall(m_stall), .ALUSrc(m_out[12]), .MemtoReg(m_out[11]), .RegWrite(m_out[10]),
      .MemRead(m_out[9]), .MemWrite(m_out[8]), .Branch(m_out[7]), .ALUOp(m_out[6:5]),
      .Jump(m_out[4]), .IRWrite(m_out[3]), .PCWrite(m_out[2]), .illegal_instr(m_out[1]),
      .mem_error(m_out[0])
   );

   multicycle_controller #(.MEM_TIMEOUT(0), .SUPPORT_JUMP(1'b0)) dut_nj (
      .clk(clk), .reset(reset), .Opcode(Opcode), .imem_ready(n_imem), .dmem_ready(dmem_ready),
      .stall(n_stall), .ALUSrc(n_out[12]), .MemtoReg(n_out[11]), .RegWrite(n_out[10]),
      .MemRead(n_out[9]), .MemWrite(n_out[8]), .Branch(n_out[7]), .ALUOp(n_out[6:5]),
      .Jump(n_out[4]), .IRWrite(n_out[3]), .PCWrite(n_out[2]), .illegal_instr(n_out[1]),
      .mem_error(n_out[0])
   );

   function automatic bit is_legal(input logic [6:0] op, input bit sj);
      case (op)
         OpR, OpI, OpLw, OpSw, OpBeq, OpLui: return 1'b1;
         OpJal, OpJalr, OpAuipc:             return sj;
         default:                            return 1'b0;
      endcase
   endfunction

   // Expected outputs for one cycle spent in phase ph with the given latched opcode.
   function automatic logic [12:0] model(input int ph, input logic [6:0] op, input bit sj,
                                         input bit stl, input bit imem, input bit err);
      logic [12:0] v;
      bit legal, lw, sw, beq, jmp;
      v     = '0;
      legal = is_legal(op, sj);
      lw    = legal && (op == OpLw);
      sw    = legal && (op == OpSw);
      beq   = legal && (op == OpBeq);
      jmp   = legal && (op == OpJal || op == OpJalr);
      if (legal) begin
         v[12]  = (op == OpI || op == OpLw || op == OpSw || op == OpLui ||
                   op == OpJalr || op == OpAuipc);
         v[6:5] = (lw || sw) ? 2'b00 : beq ? 2'b01 : (op == OpR || op == OpI) ? 2'b10 : 2'b11;
      end
      case (ph)
         PhF: begin v[3] = imem && !stl; v[0] = err; end
         PhD: v[1] = !legal && !stl;
         PhE: begin v[7] = beq; v[2] = beq && !stl; v[4] = jmp; end
         PhM: begin v[9] = lw; v[8] = sw; end
         PhW: begin v[10] = !stl; v[2] = !stl; v[11] = lw; v[4] = jmp; end
         default: v = '0;
      endcase
      return v;
   endfunction

   task automatic check(input string tag, input logic [12:0] exp);
      logic [12:0] got;
      @(negedge clk);
      got = use_nj ? n_out : m_out;
      n_asserts++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %b expected %b", tag, got, exp);
      end
      @(posedge clk);
      #1;
   endtask

   // Runs one instruction from FETCH to its return to FETCH, checking every cycle.
   task automatic do_instr(input logic [6:0] op, input int fwait, input int mwait,
                           input int wbstall);
      int d;
      bit sj;
      int tmo;
      d   = int'(use_nj);
      sj  = !use_nj;
      tmo = use_nj ? 0 : int'(Timeout);
      stall = 1'b0;
      for (int i = 0; i < fwait; i++) begin
         imem_ready = 1'b0;
         Opcode     = 7'($urandom);
         dmem_ready = 1'($urandom);
         check("fetch_wait", model(PhF, last_op[d], sj, 1'b0, 1'b0, pending_err[d]));
         pending_err[d] = 1'b0;
      end
      imem_ready = 1'b1;
      Opcode     = op;
      check("fetch", model(PhF, last_op[d], sj, 1'b0, 1'b1, pending_err[d]));
      pending_err[d] = 1'b0;
      last_op[d]     = op;
      imem_ready = 1'($urandom);
      Opcode     = 7'($urandom);
      check("decode", model(PhD, op, sj, 1'b0, 1'b0, 1'b0));
      if (!is_legal(op, sj)) return;
      check("exec", model(PhE, op, sj, 1'b0, 1'b0, 1'b0));
      if (op == OpBeq) return;
      if (op == OpLw || op == OpSw) begin
         for (int k = 0; k <= mwait; k++) begin
            dmem_ready = (k == mwait);
            check("mem", model(PhM, op, sj, 1'b0, 1'b0, 1'b0));
            if (dmem_ready) break;
            if (tmo > 0 && k == tmo - 1) begin
               pending_err[d] = 1'b1;
               return;
            end
         end
         dmem_ready = 1'b0;
         if (op == OpSw) return;
      end
      for (int s = 0; s < wbstall; s++) begin
         stall = 1'b1;
         check("wb_stall", model(PhW, op, sj, 1'b1, 1'b0, 1'b0));
      end
      stall = 1'b0;
      check("wb", model(PhW, op, sj, 1'b0, 1'b0, 1'b0));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      last_op[0] = '0; last_op[1] = '0;
      pending_err[0] = 1'b0; pending_err[1] = 1'b0;
      // Reset with stall and imem_ready high: reset wins, everything stays 0.
      use_nj = 1'b0; reset = 1'b1; stall = 1'b1; imem_ready = 1'b1; dmem_ready = 1'b0;
      Opcode = OpR;
      @(posedge clk);
      #1;
      check("reset_main", model(PhF, 7'd0, 1'b1, 1'b1, 1'b1, 1'b0));
      use_nj = 1'b1;
      check("reset_nj", model(PhF, 7'd0, 1'b0, 1'b1, 1'b1, 1'b0));
      use_nj = 1'b0; reset = 1'b0; stall = 1'b0; imem_ready = 1'b0;
      check("post_reset", model(PhF, 7'd0, 1'b1, 1'b0, 1'b0, 1'b0));

      do_instr(OpR, 0, 0, 0);            // add, 4-cycle latency
      do_instr(OpLw, 1, 3, 0);           // ready in the timeout cycle counts as success
      do_instr(OpSw, 0, 99, 0);          // timeout: 4 MemWrite cycles then mem_error
      do_instr(OpJal, 0, 0, 0);
      do_instr(OpI, 0, 0, 2);            // addi stalled 2 cycles in WB
      do_instr(OpBeq, 2, 0, 0);
      do_instr(OpLui, 0, 0, 0);
      do_instr(OpAuipc, 0, 0, 0);
      do_instr(OpJalr, 0, 0, 1);
      do_instr(OpSw, 0, 0, 0);
      do_instr(OpLw, 0, 0, 0);
      do_instr(7'h7f, 0, 0, 0);          // illegal opcode
      do_instr(OpR, 0, 0, 0);

      use_nj = 1'b1;
      do_instr(OpJal, 0, 0, 0);
      do_instr(OpAuipc, 1, 0, 0);
      do_instr(OpLw, 0, 6, 0);           // no timer: waits as long as needed
      do_instr(OpR, 0, 0, 0);
      use_nj = 1'b0;

      for (int n = 0; n < 40; n++) begin
         do_instr(ops[$urandom_range(0, 9)], $urandom_range(0, 2), $urandom_range(0, 5),
                  $urandom_range(0, 2));
      end
      do_instr(OpR, 0, 0, 0);

      // Reset in the expiring MEM cycle of a lw: no mem_error, all outputs drop.
      imem_ready = 1'b1; Opcode = OpLw; stall = 1'b0; dmem_ready = 1'b0;
      check("rst_fetch", model(PhF, last_op[0], 1'b1, 1'b0, 1'b1, pending_err[0]));
      pending_err[0] = 1'b0;
      imem_ready = 1'b0;
      check("rst_decode", model(PhD, OpLw, 1'b1, 1'b0, 1'b0, 1'b0));
      check("rst_exec", model(PhE, OpLw, 1'b1, 1'b0, 1'b0, 1'b0));
      for (int k = 0; k < int'(Timeout) - 1; k++) begin
         check("rst_mem", model(PhM, OpLw, 1'b1, 1'b0, 1'b0, 1'b0));
      end
      reset = 1'b1;
      check("rst_mem_last", model(PhM, OpLw, 1'b1, 1'b0, 1'b0, 1'b0));
      reset = 1'b0;
      last_op[0] = '0; last_op[1] = '0;
      check("rst_after", model(PhF, 7'd0, 1'b1, 1'b0, 1'b0, 1'b0));
      check("rst_after2", model(PhF, 7'd0, 1'b1, 1'b0, 1'b0, 1'b0));
      do_instr(OpR, 0, 0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end

endmodule
